// File: rtl/seq_gen_pkg.sv
// seq_gen_pkg: shared types and helpers for the sequence_gen serial transmitter.
//   state_t     - transmitter FSM states (IDLE, SHIFT, PAR, GAP)
//   calc_len_w  - width of a bit-length field able to hold 0..width
//   calc_gap_w  - width of the idle-gap counter (never below 1 bit)
//   eff_len     - maps a requested length to the number of bits actually sent
package seq_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_PAR,
    ST_GAP
  } state_t;

  function automatic int calc_len_w(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic int calc_gap_w(input int gap);
    int w;
    w = $clog2(gap + 1);
    return (w < 1) ? 1 : w;
  endfunction

  // A length of 0 means a full word; anything longer than a word is clamped.
  function automatic int unsigned eff_len(input int unsigned len, input int unsigned width);
    if (len == 0 || len > width) return width;
    return len;
  endfunction

endpackage

// File: rtl/seq_shift_reg.sv
// seq_shift_reg: loadable shift register feeding the serial output of sequence_gen.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   load       - capture load_data/load_len (load_len must already be 1..WIDTH)
//   load_data  - parallel word
//   load_len   - number of valid bits in load_data
//   shift      - advance to the next bit
//   par_load   - (SEQ_GEN_PARITY_EN only) replace the register with the parity bit
//   head       - bit currently presented on the serial line
//   count      - bits still to be presented, including head
module seq_shift_reg
  import seq_gen_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1,
  parameter int LEN_W     = calc_len_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic [LEN_W-1:0] load_len,
  input  logic             shift,
`ifdef SEQ_GEN_PARITY_EN
  input  logic             par_load,
`endif
  output logic             head,
  output logic [LEN_W-1:0] count
);

  localparam int HEAD = (MSB_FIRST != 0) ? WIDTH - 1 : 0;

  logic [WIDTH-1:0] sreg;
`ifdef SEQ_GEN_PARITY_EN
  logic parity;
`endif

  assign head = sreg[HEAD];

  // Unused bits are zeroed at load time and the shift fills with zeros, so the
  // head bit reads 0 as soon as the word (and parity) has been shifted out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg  <= '0;
      count <= '0;
`ifdef SEQ_GEN_PARITY_EN
      parity <= 1'b0;
`endif
    end else if (load) begin
      if (MSB_FIRST != 0) sreg <= load_data << (WIDTH - int'(load_len));
      else                sreg <= load_data & ({WIDTH{1'b1}} >> (WIDTH - int'(load_len)));
      count <= load_len;
`ifdef SEQ_GEN_PARITY_EN
      parity <= 1'b0;
    end else if (par_load) begin
      // The last data bit is folded in here since it is still at the head.
      sreg   <= WIDTH'(parity ^ head) << HEAD;
      count  <= '0;
      parity <= 1'b0;
`endif
    end else if (shift) begin
      sreg <= (MSB_FIRST != 0) ? (sreg << 1) : (sreg >> 1);
      if (count != '0) count <= count - LEN_W'(1);
`ifdef SEQ_GEN_PARITY_EN
      parity <= parity ^ head;
`endif
    end
  end

endmodule

// File: rtl/sequence_gen.sv
// sequence_gen: serial pattern transmitter. Accepts a word over valid/ready and
// shifts it out one bit per clock, then inserts GAP idle cycles.
// Optional feature macro: SEQ_GEN_PARITY_EN appends an even-parity bit per word.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   in_valid    - load request
//   in_data     - word to send, bits [in_len-1:0] used
//   in_len      - bits to send (0 or >WIDTH means WIDTH)
//   in_ready    - word can be accepted this cycle
//   data        - serial bit, 0 whenever data_valid is 0
//   data_valid  - data carries a bit this cycle
//   busy        - high in every state except IDLE
//   done        - one-cycle pulse after the final transmitted bit
module sequence_gen
  import seq_gen_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int GAP       = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             in_data,
  input  logic [$clog2(WIDTH+1)-1:0]   in_len,
  output logic                         in_ready,
  output logic                         data,
  output logic                         data_valid,
  output logic                         busy,
  output logic                         done
);

  localparam int LEN_W = calc_len_w(WIDTH);
  localparam int GAP_W = calc_gap_w(GAP);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  state_t           state, state_n;
  logic             in_ready_n, data_valid_n, done_n, word_end;
  logic [GAP_W-1:0] gap_cnt, gap_n;
  logic             load, shift;
  logic             head;
  logic [LEN_W-1:0] count, load_len;
`ifdef SEQ_GEN_PARITY_EN
  logic             par_load;
`endif

  assign load_len = LEN_W'(eff_len(32'(in_len), WIDTH));

  // The shift register head is itself a flop and reads 0 once a word is out,
  // so it drives the serial line directly.
  assign data = head;

  seq_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST),
    .LEN_W     (LEN_W)
  ) u_shift (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (in_data),
    .load_len  (load_len),
    .shift     (shift),
`ifdef SEQ_GEN_PARITY_EN
    .par_load  (par_load),
`endif
    .head      (head),
    .count     (count)
  );

  // State and registered outputs. in_ready stays low through reset and rises on
  // the first edge after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      in_ready   <= 1'b0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      gap_cnt    <= '0;
    end else begin
      state      <= state_n;
      in_ready   <= in_ready_n;
      data_valid <= data_valid_n;
      busy       <= (state_n != ST_IDLE);
      done       <= done_n;
      gap_cnt    <= gap_n;
    end
  end

  // Next-state and next-output logic. Outputs are computed for the state being
  // entered so that they appear registered in that state's first cycle.
  always_comb begin
    state_n      = state;
    in_ready_n   = 1'b0;
    data_valid_n = 1'b0;
    done_n       = 1'b0;
    gap_n        = gap_cnt;
    load         = 1'b0;
    shift        = 1'b0;
    word_end     = 1'b0;
`ifdef SEQ_GEN_PARITY_EN
    par_load     = 1'b0;
`endif

    case (state)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          load         = 1'b1;
          data_valid_n = 1'b1;
          state_n      = ST_SHIFT;
        end else begin
          in_ready_n = 1'b1;
        end
      end

      ST_SHIFT: begin
        if (count == LEN_W'(1)) begin
`ifdef SEQ_GEN_PARITY_EN
          par_load     = 1'b1;
          data_valid_n = 1'b1;
          state_n      = ST_PAR;
`else
          shift    = 1'b1;
          word_end = 1'b1;
`endif
        end else begin
          shift        = 1'b1;
          data_valid_n = 1'b1;
        end
      end

`ifdef SEQ_GEN_PARITY_EN
      ST_PAR: begin
        shift    = 1'b1;
        word_end = 1'b1;
      end
`endif

      ST_GAP: begin
        if (gap_cnt == '0) begin
          state_n    = ST_IDLE;
          in_ready_n = 1'b1;
        end else begin
          gap_n = gap_cnt - GAP_W'(1);
        end
      end

      default: state_n = ST_IDLE;
    endcase

    // Word finished: pulse done and either idle out the gap or accept at once.
    if (word_end) begin
      done_n = 1'b1;
      if (GAP == 0) begin
        state_n    = ST_IDLE;
        in_ready_n = 1'b1;
      end else begin
        state_n = ST_GAP;
        gap_n   = GAP_LOAD;
      end
    end
  end

endmodule
